// File: rtl/cassette_recorder.sv
// Cassette recorder: slices the DAC output into a square wave, decodes bit
// periods measured in Q ticks into bytes, buffers them in a 4-entry FIFO and
// writes them to SDRAM one byte at a time through a request/acknowledge handshake.
module cassette_recorder #(
    parameter int THRESH = 560,
    parameter int GAP    = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Q,
    input  logic        en,
    input  logic        arm,
    input  logic [5:0]  dac,
    output logic [24:0] sdram_addr,
    output logic [7:0]  sdram_data,
    output logic        sdram_we,
    input  logic        sdram_ready,
    output logic [24:0] byte_count,
    output logic        overflow,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a byte in the FIFO and address space left
    // REQ   | sdram_we high, holding addr/data until sdram_ready
    // DONE  | one-clk recovery after the acknowledge
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [11:0] THRESH_V = 12'(THRESH);
    localparam logic [11:0] GAP_V    = 12'(GAP);
    localparam logic [24:0] ADDR_MAX = '1;

    state_t      state, state_next;
    logic        level, level_next, rise;
    logic        en_q, arm_q, arm_rise, en_fall, run;
    logic [11:0] period;
    logic        started;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        sample, is_gap, bit_val, push;
    logic [7:0]  push_byte;
    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_cnt;
    logic        full, push_ok, pop;
    logic        arm_pend;

    assign arm_rise = arm & ~arm_q;
    assign en_fall  = ~en & en_q;
    assign run      = en & arm;

    // Hysteresis slicer: above 35 goes high, below 28 goes low, otherwise holds.
    always_comb begin
        level_next = level;
        if (dac >= 6'd36)
            level_next = 1'b1;
        else if (dac <= 6'd27)
            level_next = 1'b0;
    end

    assign rise = level_next & ~level;

    // Slicer level and edge-detect history for en and arm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            en_q  <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            level <= level_next;
            en_q  <= en;
            arm_q <= arm;
        end
    end

    // Decode the period that just ended at a slicer rising edge.
    always_comb begin
        sample    = rise & run & started & ~arm_rise;
        is_gap    = (period == GAP_V);
        bit_val   = (period < THRESH_V);
        push_byte = {bit_val, shreg[7:1]};
        push      = sample & ~is_gap & (bit_cnt == 3'd7);
    end

    // Period counter and LSB-first shift register; the first edge after
    // enabling only starts timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period  <= '0;
            started <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (arm_rise || en_fall) begin
            if (arm_rise)
                period <= '0;
            started <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (run && rise) begin
            started <= 1'b1;
            period  <= '0;
            if (started) begin
                if (is_gap) begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end else begin
                    shreg   <= push_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end else if (run && Q && period != GAP_V) begin
            period <= period + 12'd1;
        end
    end

    assign full    = (fifo_cnt == 3'd4);
    assign push_ok = push & (~full | pop);

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_byte;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else if (arm_rise) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push && !push_ok)
                overflow <= 1'b1;
        end
    end

    // Writer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Writer next state; the FIFO head is popped on the IDLE->REQ transition.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != 3'd0 && sdram_addr != ADDR_MAX && !arm_rise) begin
                    state_next = REQ;
                    pop        = 1'b1;
                end
            end
            REQ: begin
                if (sdram_ready)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write request, address and count; an arm during an outstanding write
    // clears the address only once that write is acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdram_addr <= '0;
            sdram_data <= '0;
            sdram_we   <= 1'b0;
            byte_count <= '0;
            arm_pend   <= 1'b0;
        end else begin
            if (pop) begin
                sdram_data <= mem[rd_ptr];
                sdram_we   <= 1'b1;
            end
            if (state == REQ && sdram_ready) begin
                sdram_we <= 1'b0;
                arm_pend <= 1'b0;
                if (arm_pend || arm_rise) begin
                    sdram_addr <= '0;
                    byte_count <= '0;
                end else begin
                    sdram_addr <= sdram_addr + 25'd1;
                    byte_count <= byte_count + 25'd1;
                end
            end else if (arm_rise) begin
                if (state == REQ) begin
                    arm_pend <= 1'b1;
                end else begin
                    sdram_addr <= '0;
                    byte_count <= '0;
                end
            end
        end
    end

    assign busy = (fifo_cnt != 3'd0) | sdram_we;

endmodule
